// File: rtl/cust_hp_filter.sv
// rtl/cust_hp_filter.sv - time-multiplexed multi-channel first-order IIR high-pass (DC removal) filter
// Define CUST_HPF_SATURATE_EN to clamp output and state instead of wrapping.
module cust_hp_filter #(
    parameter int CHANNELS     = 5,
    parameter int CHANNELS_PW2 = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             chan_in_sample,
    input  logic [CHANNELS_PW2-1:0] chan_in_num,
    input  logic                    chan_in_valid,
    output logic                    chan_in_read,
    output logic [15:0]             chan_out_sample,
    output logic [CHANNELS_PW2-1:0] chan_out_num,
    output logic                    chan_out_valid,
    input  logic                    chan_out_read,
    input  logic [15:0]             coeff
);

    localparam int DEPTH = 1 << CHANNELS_PW2;
    // Channel count only documents intended use; the state array is sized by the index width.
    localparam int unused_channels = CHANNELS;

    logic [31:0]             state_q [DEPTH];
    logic [15:0]             out_sample_q, out_sample_d;
    logic [CHANNELS_PW2-1:0] out_num_q;
    logic                    out_valid_q;

    logic                    accept;
    logic [31:0]             a_cur;
    logic signed [17:0]      out_full;
    logic signed [33:0]      diff;
    logic signed [49:0]      prod;
    logic signed [49:0]      a_sum;
    logic [31:0]             a_next;

    assign chan_in_read    = !out_valid_q || chan_out_read;
    assign accept          = chan_in_valid && chan_in_read;
    assign chan_out_sample = out_sample_q;
    assign chan_out_num    = out_num_q;
    assign chan_out_valid  = out_valid_q;

    always_comb begin
        a_cur    = state_q[chan_in_num];
        out_full = $signed({2'b00, chan_in_sample}) - $signed({2'b00, a_cur[31:16]})
                 + 18'sd32768;
        diff     = $signed({2'b00, chan_in_sample, 16'h0000}) - $signed({2'b00, a_cur});
        prod     = $signed({34'd0, coeff}) * $signed({{16{diff[33]}}, diff});
        a_sum    = $signed({18'd0, a_cur}) + (prod >>> 16);
    end

`ifdef CUST_HPF_SATURATE_EN
    always_comb begin
        out_sample_d = out_full[15:0];
        if (out_full[17])
            out_sample_d = 16'h0000;
        else if (out_full[16])
            out_sample_d = 16'hFFFF;

        a_next = a_sum[31:0];
        if (a_sum[49])
            a_next = 32'h0000_0000;
        else if (|a_sum[48:32])
            a_next = 32'hFFFF_FFFF;
    end
`else
    logic unused_hi_bits;

    always_comb begin
        out_sample_d = out_full[15:0];
        a_next       = a_sum[31:0];
    end

    assign unused_hi_bits = ^{out_full[17:16], a_sum[49:32]};
`endif

    // State write lands on the accept edge, so a following same-channel sample sees it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                state_q[i] <= 32'h8000_0000;
            out_sample_q <= 16'h0000;
            out_num_q    <= '0;
            out_valid_q  <= 1'b0;
        end else if (accept) begin
            state_q[chan_in_num] <= a_next;
            out_sample_q         <= out_sample_d;
            out_num_q            <= chan_in_num;
            out_valid_q          <= 1'b1;
        end else if (chan_out_read) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cust_hp_filter.sv
// tb/tb_cust_hp_filter.sv - randomized self-checking bench for cust_hp_filter against an arithmetic model
module tb_cust_hp_filter;

    logic        clk;
    logic        reset;
    logic [15:0] in_sample;
    logic [6:0]  in_num;
    logic        in_valid;
    logic        in_read;
    logic [15:0] out_sample;
    logic [6:0]  out_num;
    logic        out_valid;
    logic        out_read;
    logic [15:0] coeff;

    int checks = 0;
    int errors = 0;

    longint mstate [128];
    logic        exp_valid;
    logic [15:0] exp_sample;
    logic [6:0]  exp_num;
    logic [22:0] sb_q [$];

    cust_hp_filter #(.CHANNELS(5), .CHANNELS_PW2(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .chan_in_sample (in_sample),
        .chan_in_num    (in_num),
        .chan_in_valid  (in_valid),
        .chan_in_read   (in_read),
        .chan_out_sample(out_sample),
        .chan_out_num   (out_num),
        .chan_out_valid (out_valid),
        .chan_out_read  (out_read),
        .coeff          (coeff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint floor_div65536(longint p);
        if (p >= 0) return p / 65536;
        return -((-p + 65535) / 65536);
    endfunction

    function automatic logic [15:0] model_accept(int ch, longint x, longint c);
        longint a, o, na;
        a = mstate[ch];
        o = x - (a / 65536) + 32768;
`ifdef CUST_HPF_SATURATE_EN
        if (o < 0) o = 0;
        if (o > 65535) o = 65535;
`else
        o = o & 64'hFFFF;
`endif
        na = a + floor_div65536(c * (x * 65536 - a));
`ifdef CUST_HPF_SATURATE_EN
        if (na < 0) na = 0;
        if (na > 64'hFFFF_FFFF) na = 64'hFFFF_FFFF;
`else
        na = na & 64'hFFFF_FFFF;
`endif
        mstate[ch] = na;
        return o[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mstate[i] = 64'h8000_0000;
        exp_valid  = 1'b0;
        exp_sample = 16'h0000;
        exp_num    = 7'd0;
        sb_q.delete();
    endtask

    // One clock: model the handshake from the inputs currently driven, then settle past the edge.
    task automatic tick();
        logic acc;
        logic [15:0] r;
        acc = in_valid && (!exp_valid || out_read);
        @(posedge clk);
        if (acc) begin
            r = model_accept(int'(in_num), longint'(in_sample), longint'(coeff));
            exp_sample = r;
            exp_num    = in_num;
            exp_valid  = 1'b1;
            sb_q.push_back({in_num, r});
        end else if (out_read) begin
            exp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        in_valid = 1'b0;
        out_read = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_read = 1'b0; in_sample = 16'h0; in_num = 7'd0; coeff = 16'd3991;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 16'h0 || out_num !== 7'd0 || in_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_init valid=%b sample=%h num=%0d in_read=%b, want 0 0000 0 1",
                     out_valid, out_sample, out_num, in_read);
        end
        reset = 1'b1;
        out_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_num = 7'(i + 5); in_sample = 16'($urandom);
            tick();
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 16'h0 || out_num !== 7'd0 || in_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid valid=%b sample=%h num=%0d in_read=%b, want 0 0000 0 1",
                     out_valid, out_sample, out_num, in_read);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        out_read = 1'b1;
        in_valid = 1'b1; in_num = 7'd1; in_sample = 16'h8000;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sample !== 16'h8000 || out_num !== 7'd1) begin
            errors++;
            $display("FAIL reset_first valid=%b sample=%h num=%0d, want 1 8000 1", out_valid, out_sample, out_num);
        end
        tick();
    endtask

    task automatic test_dc_step();
        logic [15:0] prev;
        apply_reset();
        coeff = 16'd3991;
        prev  = 16'hFFFF;
        for (int k = 0; k < 220; k++) begin
            in_valid = 1'b1; in_num = 7'd1; in_sample = 16'h9000;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sample !== exp_sample || out_num !== 7'd1) begin
                errors++;
                $display("FAIL dc_model k=%0d valid=%b sample=%0d num=%0d, want 1 %0d 1",
                         k, out_valid, out_sample, out_num, exp_sample);
            end
            if (k == 0) begin
                checks++;
                if (out_sample !== 16'd36864) begin
                    errors++;
                    $display("FAIL dc_first got %0d want 36864", out_sample);
                end
            end
            if (k == 1) begin
                checks++;
                if (out_sample !== 16'd36615) begin
                    errors++;
                    $display("FAIL dc_second got %0d want 36615", out_sample);
                end
            end
            checks++;
            if (out_sample > prev) begin
                errors++;
                $display("FAIL dc_monotonic k=%0d got %0d after %0d", k, out_sample, prev);
            end
            prev = out_sample;
        end
        checks++;
        if (out_sample < 16'd32767 || out_sample > 16'd32769) begin
            errors++;
            $display("FAIL dc_settle got %0d want 32768+-1", out_sample);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_isolation();
        int chs [5] = '{1, 2, 4, 8, 16};
        apply_reset();
        coeff = 16'd3991;
        for (int r = 0; r < 30; r++) begin
            for (int j = 0; j < 5; j++) begin
                in_valid  = 1'b1;
                in_num    = 7'(chs[j]);
                in_sample = (chs[j] == 1) ? 16'h9000 : 16'h8000;
                tick();
                checks++;
                if (out_valid !== 1'b1 || out_num !== 7'(chs[j]) || out_sample !== exp_sample) begin
                    errors++;
                    $display("FAIL iso r=%0d ch=%0d valid=%b num=%0d sample=%0d, want 1 %0d %0d",
                             r, chs[j], out_valid, out_num, out_sample, chs[j], exp_sample);
                end
                if (chs[j] != 1) begin
                    checks++;
                    if (out_sample !== 16'h8000) begin
                        errors++;
                        $display("FAIL iso_quiet ch=%0d got %h want 8000", chs[j], out_sample);
                    end
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [22:0] e;
        int popped;
        apply_reset();
        coeff = 16'd2000;
        out_read = 1'b0;
        in_valid = 1'b1; in_num = 7'd9; in_sample = 16'hA000;
        tick();
        for (int k = 0; k < 4; k++) begin
            in_sample = 16'($urandom);
            checks++;
            if (in_read !== 1'b0 || out_valid !== 1'b1 || out_sample !== exp_sample || out_num !== 7'd9) begin
                errors++;
                $display("FAIL bp_hold k=%0d in_read=%b valid=%b sample=%h num=%0d, want 0 1 %h 9",
                         k, in_read, out_valid, out_sample, out_num, exp_sample);
            end
            tick();
        end
        popped = 0;
        for (int k = 0; k < 600; k++) begin
            in_valid  = 1'($urandom);
            in_num    = 7'($urandom_range(0, 7));
            in_sample = 16'($urandom);
            out_read  = ($urandom_range(0, 3) != 0);
            coeff     = 16'($urandom);
            #1;
            checks++;
            if (in_read !== (!exp_valid || out_read)) begin
                errors++;
                $display("FAIL bp_in_read k=%0d got %b want %b", k, in_read, !exp_valid || out_read);
            end
            if (out_valid && out_read) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_dup k=%0d output taken with nothing outstanding", k);
                end else begin
                    e = sb_q.pop_front();
                    popped++;
                    if ({out_num, out_sample} !== e) begin
                        errors++;
                        $display("FAIL bp_order k=%0d num=%0d sample=%h, want %0d %h",
                                 k, out_num, out_sample, e[22:16], e[15:0]);
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0;
        out_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) begin
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    popped++;
                    checks++;
                    if ({out_num, out_sample} !== e) begin
                        errors++;
                        $display("FAIL bp_drain num=%0d sample=%h, want %0d %h", out_num, out_sample, e[22:16], e[15:0]);
                    end
                end
            end
            tick();
        end
        checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_loss outstanding=%0d valid=%b popped=%0d, want 0 0", sb_q.size(), out_valid, popped);
        end
    endtask

    task automatic test_coeff0();
        apply_reset();
        coeff = 16'd0;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; in_num = 7'd3; in_sample = 16'h1234;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sample !== 16'h1234 || out_sample !== exp_sample || out_num !== 7'd3) begin
                errors++;
                $display("FAIL coeff0 k=%0d valid=%b sample=%h num=%0d, want 1 1234 3", k, out_valid, out_sample, out_num);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        logic [15:0] want;
        apply_reset();
        coeff = 16'hFFFF;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1; in_num = 7'd0; in_sample = 16'h0000;
            tick();
        end
        checks++;
        if (out_sample !== exp_sample) begin
            errors++;
            $display("FAIL sat_low got %h want %h", out_sample, exp_sample);
        end
        in_sample = 16'hFFFF;
        tick();
`ifdef CUST_HPF_SATURATE_EN
        want = 16'hFFFF;
`else
        want = 16'h7FFF;
`endif
        checks++;
        if (out_sample !== want || out_sample !== exp_sample) begin
            errors++;
            $display("FAIL sat_high got %h want %h (model %h)", out_sample, want, exp_sample);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_dc_step();
        test_isolation();
        test_backpressure();
        test_coeff0();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cust_hp_filter.md
Name: cust_hp_filter

Overview:
- Multi-channel, time-multiplexed first-order IIR high-pass filter (DC/offset removal) for 16-bit offset-binary amplifier samples.
- Samples from many channels arrive interleaved on one stream, each tagged with a channel index.
- A per-channel low-pass state is tracked, and sample minus that state is output, re-centred at midscale.
- Sits between the acquisition de-serialiser and the downstream stimulation/spike-detection logic, using valid/read handshakes on both sides.

Parameters:
- CHANNELS, 5: number of channels in use; sets the state-array depth as 2**CHANNELS_PW2, independent of CHANNELS; CHANNELS is informational only.
- CHANNELS_PW2, 7: width of the channel-index buses; state array holds 2**CHANNELS_PW2 entries.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- chan_in_sample  in  16  input sample, offset binary (0x8000 = 0 V).
- chan_in_num  in  CHANNELS_PW2  binary channel index of chan_in_sample.
- chan_in_valid  in  1  input sample/index valid.
- chan_in_read  out  1  block can accept an input this cycle.
- chan_out_sample  out  16  filtered sample, offset binary.
- chan_out_num  out  CHANNELS_PW2  channel index of chan_out_sample.
- chan_out_valid  out  1  output holds a valid result.
- chan_out_read  in  1  consumer takes the output this cycle.
- coeff  in  16  filter coefficient, unsigned Q0.16. Corner frequency fc gives coeff = round((1-exp(-2*pi*fc/fs))*65536); 300 Hz at 30 kS/s gives 3991.

Behaviour:
- Reset (reset=0, async):
  - chan_out_valid=0, chan_out_sample=0, chan_out_num=0.
  - Every state entry is set to 0x8000_0000, i.e. 32768.0 in unsigned 16.16.
- chan_in_read = !chan_out_valid || chan_out_read (combinational).
- Accept occurs on a rising edge where chan_in_valid && chan_in_read.
- Processing on accept, with n = chan_in_num, x = chan_in_sample, A = state[n] (32-bit unsigned 16.16), Ai = A[31:16]:
  - out = x - Ai + 32768, computed signed 18-bit, saturated to [0, 65535].
  - d = (x<<16) - A, signed 34-bit.
  - A' = A + ((coeff*d) >>> 16), arithmetic shift, product signed 50-bit.
  - A' is clamped to [0, 0xFFFF_FFFF] and written to state[n] on the same edge.
  - chan_out_sample <= out; chan_out_num <= n; chan_out_valid <= 1.
  - coeff is sampled at the accept edge only; it may change at any time otherwise.
- Latency: one clock from accept to chan_out_valid. Throughput: one sample per clock when chan_out_read is held at 1.
- Output hold: when chan_out_valid=1 and chan_out_read=0, all outputs hold and no input is accepted.
- Drain: a read with no simultaneous accept sets chan_out_valid <= 0.
- Simultaneous read and accept: the output is replaced by the new result and valid stays 1.
- Back-to-back samples on the same channel use the updated state, because the state write completes at the accept edge (no hazard).
- Channel isolation: only state[n] changes on an accept.
- coeff=0: state frozen, output = x - Ai + 32768.
- coeff=65535: state tracks x almost fully each sample.
- Reset mid-stream discards any pending output and reinitialises all states.

Optional Feature:
- Macro CUST_HPF_SATURATE_EN.
- Defined: out and A' are saturated as described above.
- Not defined: out is the low 16 bits of the 18-bit result (wrap-around). A' is the low 32 bits of the sum (wrap-around). Saves logic when input range is guaranteed safe.
- All other behaviour is identical.

Test Plan:
- Reset check: assert reset=0 mid-stream -> chan_out_valid=0, chan_out_sample=0, chan_in_read=1. After release, the first channel-1 sample of 0x8000 gives output 0x8000.
- DC step, coeff=3991, ch1 x=0x9000 every sample:
  - output #1 = 36864 (0x9000), output #2 = 36615;
  - outputs decay monotonically toward 32768 and settle within ±1 after about 200 samples.
- Channel isolation: interleave ch 1,2,4,8,16, one per clock; ch1 gets 0x9000, the others 0x8000 -> the others output 0x8000 constantly while ch1 decays as in the DC-step test; chan_out_num equals the input index, one cycle later.
- Backpressure: hold chan_out_read=0 with valid input -> chan_in_read=0 after the first accept and the output holds. Release -> exactly one result per accepted input, with no loss or duplication.
- coeff=0 with ch3 x=0x1234 repeated -> every output is 0x1234; the state stays at 0x8000.
- Saturation (CUST_HPF_SATURATE_EN defined): ch0 x=0xFFFF with state forced low via a prior long run at x=0x0000 and coeff=65535 -> output clamps at 65535 with no wrap. Without the macro, the same stimulus wraps.
